lcd_write_ctrl: RTL

Single-clock LCD write controller sitting on the read side of the 32-bit pixel/command FIFO. It pops one 32-bit word at a time, decodes it as a command, a parameter, an RGB888 pixel or a delay, and replays it as one write beat on a 16-bit 8080-style parallel LCD bus (CS/DC/WR strobes). It is the consumer that drains the FIFO into the panel.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_delay_timer.sv | 57 +++++
 rtl/lcd_write_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD write controller: FIFO word field positions,
// word-type encodings, controller state encoding and the RGB565 packer.
// ----------------------------------------------------------------------------
package lcd_pkg;

    // FIFO word layout: [31:26] ignored, [25:24] type, [23:0] payload
    localparam int unsigned TYPE_MSB  = 25;
    localparam int unsigned TYPE_LSB  = 24;
    localparam int unsigned BYTE_MSB  = 7;
    localparam int unsigned DELAY_MSB = 15;
    localparam int unsigned RED_MSB   = 23;
    localparam int unsigned RED_LSB   = 19;
    localparam int unsigned GRN_MSB   = 15;
    localparam int unsigned GRN_LSB   = 10;
    localparam int unsigned BLU_MSB   = 7;
    localparam int unsigned BLU_LSB   = 3;

    localparam logic [1:0] TYPE_CMD   = 2'b00;
    localparam logic [1:0] TYPE_PARAM = 2'b01;
    localparam logic [1:0] TYPE_PIXEL = 2'b10;
    localparam logic [1:0] TYPE_DELAY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WR_LOW  = 3'd2,
        ST_WR_HIGH = 3'd3,
        ST_DELAY   = 3'd4
    } lcdState_t;

    // Pack already-truncated colour channels into one RGB565 bus word
    function automatic logic [15:0] packRgb565(input logic [4:0] red5,
                                               input logic [5:0] grn6,
                                               input logic [4:0] blu5);
        return {red5, grn6, blu5};
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// ----------------------------------------------------------------------------
// lcd_delay_timer
// Down-counting delay timer for delay words. A load strobe captures a 16-bit
// unit count; while enabled, a prescale counter divides the clock by PRESCALE
// and decrements the unit counter. o_done is high during the last cycle of
// the delay, or immediately when the loaded count is zero, so the owning FSM
// spends max(1, count*PRESCALE) cycles in its delay state.
// Only instantiated when LCD_DELAY_CMD_EN is defined.
// Ports:
//   i_clock   system clock
//   i_nReset  synchronous active-low reset
//   i_load    capture i_count and restart the prescaler
//   i_count   delay length in units
//   i_enable  count down (owner is in its delay state)
//   o_done    delay expires at the end of this cycle
// ----------------------------------------------------------------------------
module lcd_delay_timer #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic        i_clock,
    input  logic        i_nReset,
    input  logic        i_load,
    input  logic [15:0] i_count,
    input  logic        i_enable,
    output logic        o_done
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_r;
    logic [15:0]      unit_r;

    // Prescale and unit down-counters
    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            pre_r  <= '0;
            unit_r <= 16'd0;
        end else if (i_load) begin
            pre_r  <= PRE_LAST;
            unit_r <= i_count;
        end else if (i_enable) begin
            if (pre_r == '0) begin
                pre_r <= PRE_LAST;
                if (unit_r != 16'd0) begin
                    unit_r <= unit_r - 16'd1;
                end
            end else begin
                pre_r <= pre_r - PRE_W'(1);
            end
        end
    end

    // Last cycle: final prescale tick of the final unit, or a zero-length delay
    assign o_done = (unit_r == 16'd0) || ((unit_r == 16'd1) && (pre_r == '0));

endmodule

// File: rtl/lcd_write_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_write_ctrl
// Drains a show-ahead 32-bit FIFO onto a 16-bit 8080-style LCD bus. Each word
// is popped in IDLE and replayed as one write beat (SETUP, WR_LOW, WR_HIGH)
// or, for delay words, as an idle wait.
// Build option: LCD_DELAY_CMD_EN - when defined, type-11 words are timed
// delays; when undefined they are popped and dropped with no bus activity.
// Ports:
//   i_clock      system clock
//   i_nReset     synchronous active-low reset
//   i_fifoData   FIFO head word (valid while i_fifoEmpty=0)
//   i_fifoEmpty  FIFO empty flag
//   o_fifoRead   pop strobe, one cycle per consumed word
//   o_lcdData    LCD data bus
//   o_lcdDc      0=command, 1=data
//   o_lcdWrN     write strobe, active low
//   o_lcdCsN     chip select, active low
//   o_busy       high whenever the controller is not IDLE
// ----------------------------------------------------------------------------
module lcd_write_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2,
    parameter int unsigned DELAY_PRESCALE = 50
) (
    input  logic        i_clock,
    input  logic        i_nReset,
    input  logic [31:0] i_fifoData,
    input  logic        i_fifoEmpty,
    output logic        o_fifoRead,
    output logic [15:0] o_lcdData,
    output logic        o_lcdDc,
    output logic        o_lcdWrN,
    output logic        o_lcdCsN,
    output logic        o_busy
);

    localparam int unsigned MAX_PHASE = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(MAX_PHASE + 1);
    localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(WR_LOW_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HIGH_LAST = PHASE_W'(WR_HIGH_CYCLES - 1);

    lcdState_t          state_r;
    lcdState_t          stateNext_s;
    logic [PHASE_W-1:0] phaseCnt_r;
    logic               pop_s;
    logic [1:0]         wordType_s;
    logic               isDelay_s;
    logic [15:0]        beatData_s;
    logic               beatDc_s;
    logic               wrN_r;
    logic               csN_r;
    logic               dc_r;
    logic               busy_r;
    logic [15:0]        data_r;
    logic               unusedBits_s;

    assign wordType_s   = i_fifoData[TYPE_MSB:TYPE_LSB];
    assign isDelay_s    = (wordType_s == TYPE_DELAY);
    // Not every word bit feeds logic in every build; fold them so none dangle
    assign unusedBits_s = ^i_fifoData;

`ifdef LCD_DELAY_CMD_EN
    logic delayDone_s;

    lcd_delay_timer #(
        .PRESCALE (DELAY_PRESCALE)
    ) u_delayTimer (
        .i_clock  (i_clock),
        .i_nReset (i_nReset),
        .i_load   (pop_s & isDelay_s),
        .i_count  (i_fifoData[DELAY_MSB:0]),
        .i_enable (state_r == ST_DELAY),
        .o_done   (delayDone_s)
    );
`else
    logic [31:0] unusedPrescale_s;
    assign unusedPrescale_s = 32'(DELAY_PRESCALE);
`endif

    // Decode the head word into the bus value and DC level of its beat
    always_comb begin
        beatData_s = {8'h00, i_fifoData[BYTE_MSB:0]};
        beatDc_s   = 1'b1;
        case (wordType_s)
            TYPE_CMD:   beatDc_s   = 1'b0;
            TYPE_PIXEL: beatData_s = packRgb565(i_fifoData[RED_MSB:RED_LSB],
                                                i_fifoData[GRN_MSB:GRN_LSB],
                                                i_fifoData[BLU_MSB:BLU_LSB]);
            default:    beatDc_s   = 1'b1;
        endcase
    end

    // Next-state and pop decode; pops are gated by reset so none happen while held
    always_comb begin
        stateNext_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!i_fifoEmpty && i_nReset) begin
                    pop_s = 1'b1;
                    if (isDelay_s) begin
`ifdef LCD_DELAY_CMD_EN
                        stateNext_s = ST_DELAY;
`else
                        stateNext_s = ST_IDLE;
`endif
                    end else begin
                        stateNext_s = ST_SETUP;
                    end
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_SETUP: stateNext_s = ST_WR_LOW;
            ST_WR_LOW: begin
                if (phaseCnt_r == LOW_LAST) begin
                    stateNext_s = ST_WR_HIGH;
                end else begin
                    stateNext_s = ST_WR_LOW;
                end
            end
            ST_WR_HIGH: begin
                if (phaseCnt_r == HIGH_LAST) begin
                    stateNext_s = ST_IDLE;
                end else begin
                    stateNext_s = ST_WR_HIGH;
                end
            end
`ifdef LCD_DELAY_CMD_EN
            ST_DELAY: begin
                if (delayDone_s) begin
                    stateNext_s = ST_IDLE;
                end else begin
                    stateNext_s = ST_DELAY;
                end
            end
`endif
            default: stateNext_s = ST_IDLE;
        endcase
    end

    // State register and strobe phase counter (restarts on every state change)
    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            state_r    <= ST_IDLE;
            phaseCnt_r <= '0;
        end else begin
            state_r <= stateNext_s;
            if (stateNext_s != state_r) begin
                phaseCnt_r <= '0;
            end else if ((state_r == ST_WR_LOW) || (state_r == ST_WR_HIGH)) begin
                phaseCnt_r <= phaseCnt_r + PHASE_W'(1);
            end else begin
                phaseCnt_r <= '0;
            end
        end
    end

    // Bus outputs registered from the next state so they align with state_r
    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            wrN_r  <= 1'b1;
            csN_r  <= 1'b1;
            dc_r   <= 1'b0;
            data_r <= 16'h0000;
            busy_r <= 1'b0;
        end else begin
            wrN_r  <= (stateNext_s != ST_WR_LOW);
            csN_r  <= !(stateNext_s inside {ST_SETUP, ST_WR_LOW, ST_WR_HIGH});
            busy_r <= (stateNext_s != ST_IDLE);
            // The beat value is latched on the pop edge and held until the next beat
            if (pop_s && !isDelay_s) begin
                data_r <= beatData_s;
                dc_r   <= beatDc_s;
            end
        end
    end

    assign o_fifoRead = pop_s;
    assign o_lcdData  = data_r;
    assign o_lcdDc    = dc_r;
    assign o_lcdWrN   = wrN_r;
    assign o_lcdCsN   = csN_r;
    assign o_busy     = busy_r;

endmodule
